spi_cnt_stream: RTL and testbench

//  Parametrised SPI-slave counter bank for the LA104 FPGA. It holds NUM_CH counters of WORD_W bits each.

---
 rtl/spi_cnt_stream.sv | 148 ++++++++++++++
 tb/tb_spi_cnt_stream.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cnt_stream.sv
`timescale 1ns/1ps
// SPI-slave counter bank: one command word selects channel/mode, then each data
// word streams the selected counter on MISO and applies the mode update.
module spi_cnt_stream #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SSEL,
  input  logic MOSI,
  input  logic SCK,
  inout  wire  MISO,
  output logic busy
);

  localparam int unsigned BC_W = $clog2(WORD_W + 1);
  localparam logic [BC_W-1:0] WL = BC_W'(WORD_W);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;

  state_e              state_q, state_d;
  logic [2:0]          ssel_q, sck_q, mosi_q;
  logic [BC_W-1:0]     bit_q, bit_d;
  logic [WORD_W-1:0]   rx_q, rx_d, tx_q, tx_d;
  logic [1:0]          mode_q, mode_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [WORD_W-1:0]   cnt_q [NUM_CH];
  logic [WORD_W-1:0]   cnt_d [NUM_CH];

  logic                ssel_s, ssel_fall, sck_rise, sck_fall, mosi_s, ch_ok;
  logic [WORD_W-1:0]   rx_next, cur, upd;

  // [0],[1] synchroniser stages, [2] history for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ssel_q <= '1;
      sck_q  <= '0;
      mosi_q <= '0;
    end else begin
      ssel_q <= {ssel_q[1:0], SSEL};
      sck_q  <= {sck_q[1:0], SCK};
      mosi_q <= {mosi_q[1:0], MOSI};
    end
  end

  assign ssel_s    = ssel_q[1];
  assign ssel_fall = ssel_q[2] & ~ssel_q[1];
  assign sck_rise  = ~sck_q[2] & sck_q[1];
  assign sck_fall  = sck_q[2] & ~sck_q[1];
  assign mosi_s    = mosi_q[1];

  assign ch_ok   = (32'(ch_q) < 32'(NUM_CH));
  assign rx_next = {rx_q[WORD_W-2:0], mosi_s};

  always_comb begin
    cur = '0;
    if (ch_ok) cur = cnt_q[ch_q];
    unique case (mode_q)
      2'b00:   upd = cur;
      2'b01:   upd = cur + 1'b1;
      2'b10:   upd = cur - 1'b1;
      default: upd = rx_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    mode_d  = mode_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    if (ssel_s) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ssel_fall) begin
            state_d = CMD;
            bit_d   = '0;
            rx_d    = '0;
          end
        end
        CMD: begin
          if (sck_rise && bit_q != WL) begin
            rx_d  = rx_next;
            bit_d = bit_q + 1'b1;
            if (bit_q == WL - 1'b1) begin
              mode_d = rx_next[WORD_W-1:WORD_W-2];
              ch_d   = rx_next[CH_W-1:0];
            end
          end else if (sck_fall && bit_q == WL) begin
            state_d = DATA;
            tx_d    = cur;
            bit_d   = '0;
          end
        end
        DATA: begin
          if (sck_rise && bit_q != WL) begin
            rx_d  = rx_next;
            bit_d = bit_q + 1'b1;
          end else if (sck_fall) begin
            if (bit_q != WL) begin
              tx_d = tx_q << 1;
            end else begin
              // out-of-range channels never update and keep streaming zeros
              if (ch_ok) begin
                cnt_d[ch_q] = upd;
                tx_d        = upd;
              end else begin
                tx_d        = '0;
              end
              bit_d = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bit_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      mode_q  <= '0;
      ch_q    <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      mode_q  <= mode_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
    end
  end

  assign MISO = (state_q == DATA) ? tx_q[WORD_W-1] : 1'bz;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_spi_cnt_stream.sv
`timescale 1ns/1ps
// Directed plus randomized SPI frames against an arithmetic counter-bank model.
module tb_spi_cnt_stream;

  localparam int unsigned W   = 8;
  localparam int unsigned NCH = 4;

  logic clk = 1'b0;
  logic rst_n, ssel, mosi, sck, busy;
  wire  miso;

  pullup (miso);

  always #5 clk = ~clk;

  spi_cnt_stream #(.WORD_W(8), .NUM_CH(4), .CH_W(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .SSEL (ssel),
    .MOSI (mosi),
    .SCK  (sck),
    .MISO (miso),
    .busy (busy)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned model [NCH];
  logic [7:0]  mosi_words [8];
  logic [7:0]  rx_words [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (5) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      half();
      rx[i] = miso;
      sck = 1'b1;
      half();
      sck = 1'b0;
    end
  endtask

  task automatic fill_random(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) mosi_words[k] = 8'($urandom);
  endtask

  task automatic run_frame(input logic [7:0] cmd, input int unsigned n, input string tag);
    logic [7:0]  r;
    int unsigned mode, ch, exp;
    check({tag, "_busy_pre"}, 32'(busy), 32'd0);
    check({tag, "_miso_pre"}, 32'(miso), 32'd1);
    ssel = 1'b0;
    half();
    check({tag, "_busy_on"}, 32'(busy), 32'd1);
    xfer(cmd, r);
    mode = 32'(cmd[7:6]);
    ch   = 32'(cmd[1:0]);
    for (int unsigned k = 0; k < n; k++) begin
      xfer(mosi_words[k], r);
      rx_words[k] = r;
      exp = (ch < NCH) ? model[ch] : 0;
      check($sformatf("%s_w%0d", tag, k), 32'(r), exp);
      if (ch < NCH) begin
        case (mode)
          1: model[ch] = (model[ch] + 1) % 256;
          2: model[ch] = (model[ch] + 255) % 256;
          3: model[ch] = 32'(mosi_words[k]);
          default: ;
        endcase
      end
    end
    half();
    ssel = 1'b1;
    repeat (6) @(negedge clk);
    check({tag, "_busy_post"}, 32'(busy), 32'd0);
    check({tag, "_miso_post"}, 32'(miso), 32'd1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    rst_n = 1'b0; ssel = 1'b1; sck = 1'b0; mosi = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) model[i] = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_miso", 32'(miso), 32'd1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: plain read of channel 0
    fill_random(1);
    run_frame(8'h00, 1, "t1");
    check("t1_val", 32'(rx_words[0]), 32'h00);

    // 2: increment channel 1
    fill_random(3);
    run_frame(8'h41, 3, "t2");
    check("t2_v0", 32'(rx_words[0]), 32'h00);
    check("t2_v1", 32'(rx_words[1]), 32'h01);
    check("t2_v2", 32'(rx_words[2]), 32'h02);
    fill_random(1);
    run_frame(8'h01, 1, "t2r");
    check("t2r_val", 32'(rx_words[0]), 32'h03);
    fill_random(1);
    run_frame(8'h00, 1, "t2c0");
    check("t2c0_val", 32'(rx_words[0]), 32'h00);

    // 3: write channel 2 then increment through wrap
    mosi_words[0] = 8'hFE;
    run_frame(8'hC2, 1, "t3w");
    check("t3w_val", 32'(rx_words[0]), 32'h00);
    fill_random(3);
    run_frame(8'h42, 3, "t3i");
    check("t3i_v0", 32'(rx_words[0]), 32'hFE);
    check("t3i_v1", 32'(rx_words[1]), 32'hFF);
    check("t3i_v2", 32'(rx_words[2]), 32'h00);

    // 4: decrement channel 3 through wrap
    fill_random(2);
    run_frame(8'h83, 2, "t4");
    check("t4_v0", 32'(rx_words[0]), 32'h00);
    check("t4_v1", 32'(rx_words[1]), 32'hFF);
    fill_random(1);
    run_frame(8'h03, 1, "t4r");
    check("t4r_val", 32'(rx_words[0]), 32'hFE);

    // 5: partial data word discarded
    ssel = 1'b0;
    half();
    xfer(8'h41, r);
    for (int i = 0; i < 5; i++) begin
      mosi = 1'($urandom);
      half();
      sck = 1'b1;
      half();
      sck = 1'b0;
    end
    half();
    check("t5_miso_bit", 32'(miso), (model[1] >> 2) & 1);
    ssel = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_busy_2clk", 32'(busy), 32'd1);
    @(negedge clk);
    check("t5_busy_3clk", 32'(busy), 32'd0);
    check("t5_miso_3clk", 32'(miso), 32'd1);
    repeat (4) @(negedge clk);
    fill_random(1);
    run_frame(8'h01, 1, "t5r");
    check("t5r_val", 32'(rx_words[0]), 32'h03);

    // SSEL rise during the command word aborts the frame
    ssel = 1'b0;
    half();
    for (int i = 7; i >= 5; i--) begin
      mosi = 1'(8'h81 >> i);
      half();
      sck = 1'b1;
      half();
      sck = 1'b0;
    end
    check("abort_miso", 32'(miso), 32'd1);
    ssel = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    fill_random(1);
    run_frame(8'h01, 1, "abort_r");

    // randomized frames
    for (int n = 0; n < 24; n++) begin
      int unsigned nw;
      nw = $urandom_range(1, 4);
      fill_random(nw);
      run_frame(8'($urandom), nw, $sformatf("rnd%0d", n));
    end

    // 6: asynchronous reset mid-DATA
    mosi_words[0] = 8'h00;
    run_frame(8'hC0, 1, "t6w0");
    mosi_words[0] = 8'hA5;
    run_frame(8'hC3, 1, "t6w3");
    ssel = 1'b0;
    half();
    xfer(8'h00, r);
    for (int i = 0; i < 2; i++) begin
      mosi = 1'b1;
      half();
      sck = 1'b1;
      half();
      sck = 1'b0;
    end
    half();
    check("t6_busy_pre", 32'(busy), 32'd1);
    check("t6_miso_pre", 32'(miso), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t6_miso_async", 32'(miso), 32'd1);
    check("t6_busy_async", 32'(busy), 32'd0);
    ssel = 1'b1; sck = 1'b0; mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned i = 0; i < NCH; i++) model[i] = 0;
    repeat (4) @(negedge clk);
    for (int unsigned c = 0; c < NCH; c++) begin
      fill_random(1);
      run_frame(8'(c), 1, $sformatf("t6r%0d", c));
      check($sformatf("t6r%0d_val", c), 32'(rx_words[0]), 32'h00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
